// File: rtl/branch_pkg.sv
// Shared definitions for the branch sequencer:
// condition codes, FSM state encoding, flush counter width.
package branch_pkg;

    localparam logic [2:0] COND_ALW = 3'd0;
    localparam logic [2:0] COND_EQ  = 3'd1;
    localparam logic [2:0] COND_NE  = 3'd2;
    localparam logic [2:0] COND_MI  = 3'd3;
    localparam logic [2:0] COND_PL  = 3'd4;
    localparam logic [2:0] COND_LE  = 3'd5;
    localparam logic [2:0] COND_GT  = 3'd6;
    localparam logic [2:0] COND_NV  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational condition evaluator: maps a condition
// code plus Z/N flags to a taken decision.
module br_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic       z_i,
    input  logic       n_i,
    output logic       taken_o
);

    // Decode the condition code against the flags
    always_comb begin
        taken_o = 1'b0;
        unique case (cond_i)
            COND_ALW: taken_o = 1'b1;
            COND_EQ:  taken_o = z_i;
            COND_NE:  taken_o = ~z_i;
            COND_MI:  taken_o = n_i;
            COND_PL:  taken_o = ~n_i;
            COND_LE:  taken_o = z_i | n_i;
            COND_GT:  taken_o = ~z_i & ~n_i;
            COND_NV:  taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Conditional-branch sequencer: stalls on busy flags, evaluates,
// loads PC and holds flush. Optional stats via BRANCH_STATS_EN.
module branch_unit
    import branch_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              Z_in,
    input  logic              N_in,
    input  logic              flag_busy,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    output logic              flush,
    output logic              br_taken,
    output logic              br_done
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]       taken_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    state_e              state_q;
    logic [2:0]          cond_q;
    logic [ADDR_W-1:0]   tgt_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                taken_w;

    br_cond_eval u_eval (
        .cond_i  (cond_q),
        .z_i     (Z_in),
        .n_i     (N_in),
        .taken_o (taken_w)
    );

    assign br_ready = (state_q == ST_IDLE);

    // Branch FSM with registered strobes and flush counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cond_q   <= '0;
            tgt_q    <= '0;
            cnt_q    <= '0;
            pc_load  <= 1'b0;
            pc_next  <= '0;
            flush    <= 1'b0;
            br_taken <= 1'b0;
            br_done  <= 1'b0;
        end else begin
            pc_load <= 1'b0;
            br_done <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (br_valid) begin
                        cond_q  <= br_cond;
                        tgt_q   <= br_target;
                        state_q <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (!flag_busy) begin
                        br_taken <= taken_w;
                        if (taken_w) begin
                            pc_load <= 1'b1;
                            pc_next <= tgt_q;
                            flush   <= 1'b1;
                            cnt_q   <= CNT_INIT;
                            state_q <= ST_FLUSH;
                        end else begin
                            br_done <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        flush   <= 1'b0;
                        br_done <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // Count taken evaluations and busy-flag stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else if (state_q == ST_EVAL) begin
            if (flag_busy) begin
                stall_cnt <= stall_cnt + 16'd1;
            end else if (taken_w) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
